// File: rtl/ls_exec_unit_if.sv
// Purpose : bundles the LS-queue op handshake, data-memory req/resp bus and CDB broadcast of ls_exec_unit.
// Latency : n/a (wires only).
// Backpressure: queue side held by ls_ready/done_to_queue, memory side held by mem_gnt.
// Ports   : flush + in_* op fields (queue -> unit), ls_ready/done_to_queue (unit -> queue),
//           mem_req/we/addr/be/wdata (unit -> mem), mem_gnt/resp_valid/rdata (mem -> unit),
//           cdb_valid/tag/data and err (unit -> broadcast).
// master is the execution unit's view; slave is the surrounding queue/memory/CDB view.
interface ls_exec_unit_if #(
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = 5
);
  logic                   flush;
  logic                   in_valid;
  logic                   in_read_write;
  logic [XLEN-1:0]        in_base;
  logic [XLEN-1:0]        in_offset;
  logic [XLEN-1:0]        in_store_data;
  logic [1:0]             in_size;
  logic                   in_unsigned;
  logic [ROB_TAG_LEN-1:0] in_tag;
  logic                   ls_ready;
  logic                   done_to_queue;
  logic                   mem_req;
  logic                   mem_we;
  logic [XLEN-1:0]        mem_addr;
  logic [3:0]             mem_be;
  logic [XLEN-1:0]        mem_wdata;
  logic                   mem_gnt;
  logic                   mem_resp_valid;
  logic [XLEN-1:0]        mem_rdata;
  logic                   cdb_valid;
  logic [ROB_TAG_LEN-1:0] cdb_tag;
  logic [XLEN-1:0]        cdb_data;
  logic                   err;

  modport master (
    input  flush, in_valid, in_read_write, in_base, in_offset, in_store_data,
           in_size, in_unsigned, in_tag, mem_gnt, mem_resp_valid, mem_rdata,
    output ls_ready, done_to_queue, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           cdb_valid, cdb_tag, cdb_data, err
  );

  modport slave (
    output flush, in_valid, in_read_write, in_base, in_offset, in_store_data,
           in_size, in_unsigned, in_tag, mem_gnt, mem_resp_valid, mem_rdata,
    input  ls_ready, done_to_queue, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           cdb_valid, cdb_tag, cdb_data, err
  );
endinterface

// File: rtl/ls_exec_unit.sv
// Purpose : executes one load/store from the LS queue head over a req/gnt/resp memory bus, broadcasts loads on the CDB.
// Latency : accept at N -> mem_req at N+1; gnt N+1 + resp N+2 -> done/cdb at N+3.
// Backpressure: single outstanding op; ls_ready low outside IDLE, mem_req held until mem_gnt.
// Ports   : clk (rising edge), reset (async, active-low), bus (ls_exec_unit_if.master).
// Option  : define LS_MISALIGN_TRAP_EN to trap misaligned half/word ops (err + done, no bus access)
//           instead of forcing them onto the aligned lane.
module ls_exec_unit #(
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  ls_exec_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                 state;
  logic                   is_load;
  logic [1:0]             size_q;
  logic                   unsigned_q;
  logic [ROB_TAG_LEN-1:0] tag_q;
  logic [1:0]             lane_q;
  logic                   flush_pending;
  logic [7:0]             tmo_cnt;

  logic                   mem_req_r;
  logic                   mem_we_r;
  logic [XLEN-1:0]        mem_addr_r;
  logic [3:0]             mem_be_r;
  logic [XLEN-1:0]        mem_wdata_r;
  logic                   ls_ready_r;
  logic                   done_r;
  logic                   cdb_valid_r;
  logic [ROB_TAG_LEN-1:0] cdb_tag_r;
  logic [XLEN-1:0]        cdb_data_r;
  logic                   err_r;

  // Address generation and lane steering for the op currently presented.
  logic [XLEN-1:0] eff_addr;
  logic            misaligned;
  logic [1:0]      lane_in;
  logic [3:0]      be_in;
  logic [XLEN-1:0] wdata_in;

  always_comb begin
    eff_addr   = bus.in_base + bus.in_offset;
    misaligned = 1'b0;
    case (bus.in_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = eff_addr[0];
      default: misaligned = (eff_addr[1:0] != 2'b00);
    endcase
    // Misaligned accesses collapse onto lane 0, i.e. an aligned access.
    lane_in = misaligned ? 2'b00 : eff_addr[1:0];
    case (bus.in_size)
      2'd0:    be_in = 4'b0001 << lane_in;
      2'd1:    be_in = 4'b0011 << lane_in;
      default: be_in = 4'b1111;
    endcase
    wdata_in = bus.in_store_data << {lane_in, 3'b000};
  end

  // Load data: shift the addressed lane down, then sign/zero extend.
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] load_ext;

  always_comb begin
    rd_shift = bus.mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    load_ext = {{(XLEN-8){~unsigned_q & rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    load_ext = {{(XLEN-16){~unsigned_q & rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  // A flush arriving in the cycle the result is reported also kills the report.
  logic kill_report;
  assign kill_report = flush_pending | bus.flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      is_load       <= 1'b0;
      size_q        <= 2'd0;
      unsigned_q    <= 1'b0;
      tag_q         <= '0;
      lane_q        <= 2'd0;
      flush_pending <= 1'b0;
      tmo_cnt       <= 8'd0;
      mem_req_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= '0;
      mem_be_r      <= 4'd0;
      mem_wdata_r   <= '0;
      ls_ready_r    <= 1'b1;
      done_r        <= 1'b0;
      cdb_valid_r   <= 1'b0;
      cdb_tag_r     <= '0;
      cdb_data_r    <= '0;
      err_r         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Late responses after a timeout land here and are simply dropped.
          if (bus.in_valid && !bus.flush) begin
            is_load    <= bus.in_read_write;
            size_q     <= bus.in_size;
            unsigned_q <= bus.in_unsigned;
            tag_q      <= bus.in_tag;
            lane_q     <= lane_in;
            ls_ready_r <= 1'b0;
`ifdef LS_MISALIGN_TRAP_EN
            if (misaligned) begin
              state  <= DONE;
              done_r <= 1'b1;
              err_r  <= 1'b1;
            end else begin
              state       <= REQ;
              mem_req_r   <= 1'b1;
              mem_we_r    <= ~bus.in_read_write;
              mem_addr_r  <= {eff_addr[XLEN-1:2], 2'b00};
              mem_be_r    <= be_in;
              mem_wdata_r <= wdata_in;
            end
`else
            state       <= REQ;
            mem_req_r   <= 1'b1;
            mem_we_r    <= ~bus.in_read_write;
            mem_addr_r  <= {eff_addr[XLEN-1:2], 2'b00};
            mem_be_r    <= be_in;
            mem_wdata_r <= wdata_in;
`endif
          end
        end

        REQ: begin
          if (bus.mem_gnt || bus.flush) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_be_r    <= 4'd0;
            mem_wdata_r <= '0;
          end
          if (bus.mem_gnt) begin
            // Once granted the bus transaction must complete; a flush only mutes the report.
            state   <= WAIT;
            tmo_cnt <= 8'd0;
            if (bus.flush) flush_pending <= 1'b1;
          end else if (bus.flush) begin
            state      <= IDLE;
            ls_ready_r <= 1'b1;
          end
        end

        WAIT: begin
          if (bus.flush) flush_pending <= 1'b1;
          if (bus.mem_resp_valid) begin
            state   <= DONE;
            tmo_cnt <= 8'd0;
            done_r  <= ~kill_report;
            if (is_load) begin
              cdb_valid_r <= ~kill_report;
              cdb_tag_r   <= tag_q;
              cdb_data_r  <= load_ext;
            end
          end else if (tmo_cnt == 8'(MEM_TIMEOUT)) begin
            state   <= DONE;
            tmo_cnt <= 8'd0;
            done_r  <= ~kill_report;
            err_r   <= ~kill_report;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        DONE: begin
          state         <= IDLE;
          ls_ready_r    <= 1'b1;
          flush_pending <= 1'b0;
          done_r        <= 1'b0;
          cdb_valid_r   <= 1'b0;
          cdb_tag_r     <= '0;
          cdb_data_r    <= '0;
          err_r         <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ls_ready      = ls_ready_r;
  assign bus.mem_req       = mem_req_r;
  assign bus.mem_we        = mem_we_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_be        = mem_be_r;
  assign bus.mem_wdata     = mem_wdata_r;
  assign bus.done_to_queue = done_r & ~bus.flush;
  assign bus.cdb_valid     = cdb_valid_r & ~bus.flush;
  assign bus.cdb_tag       = cdb_tag_r;
  assign bus.cdb_data      = cdb_data_r;
  assign bus.err           = err_r & ~bus.flush;

endmodule

// File: tb/tb_ls_exec_unit.sv
// Purpose : directed self-checking bench for ls_exec_unit.
// Latency : n/a.
// Backpressure: memory gnt/resp driven per scenario; all waits bounded.
module tb_ls_exec_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  ls_exec_unit_if #(.XLEN(32), .ROB_TAG_LEN(5)) bus ();

  ls_exec_unit #(.XLEN(32), .ROB_TAG_LEN(5), .MEM_TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush          = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_read_write  = 1'b0;
    bus.in_base        = '0;
    bus.in_offset      = '0;
    bus.in_store_data  = '0;
    bus.in_size        = 2'd0;
    bus.in_unsigned    = 1'b0;
    bus.in_tag         = '0;
    bus.mem_gnt        = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  // Present an op for one cycle (cycle N); returns just after the accepting edge (cycle N+1).
  task automatic accept_op(input logic ld, input logic [31:0] base, input logic [31:0] off,
                           input logic [31:0] sdata, input logic [1:0] size,
                           input logic uns, input logic [4:0] tag);
    bus.in_valid      = 1'b1;
    bus.in_read_write = ld;
    bus.in_base       = base;
    bus.in_offset     = off;
    bus.in_store_data = sdata;
    bus.in_size       = size;
    bus.in_unsigned   = uns;
    bus.in_tag        = tag;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #12;
    checks++; if (bus.ls_ready !== 1'b1) begin failures++; $display("FAIL reset_ls_ready got=%b exp=1", bus.ls_ready); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
    checks++; if (bus.done_to_queue !== 1'b0 || bus.cdb_valid !== 1'b0 || bus.err !== 1'b0)
      begin failures++; $display("FAIL reset_pulses got done=%b cdb=%b err=%b exp=000", bus.done_to_queue, bus.cdb_valid, bus.err); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.mem_be !== 4'h0 || bus.cdb_data !== 32'h0)
      begin failures++; $display("FAIL reset_buses got addr=%h be=%h cdb=%h exp=0", bus.mem_addr, bus.mem_be, bus.cdb_data); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load_word();
    accept_op(1'b1, 32'h100, 32'h4, 32'h0, 2'd2, 1'b0, 5'd7);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL lw_req got req=%b we=%b exp req=1 we=0", bus.mem_req, bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'h104) begin failures++; $display("FAIL lw_addr got=%h exp=00000104", bus.mem_addr); end
    checks++; if (bus.mem_be !== 4'hF) begin failures++; $display("FAIL lw_be got=%b exp=1111", bus.mem_be); end
    checks++; if (bus.ls_ready !== 1'b0) begin failures++; $display("FAIL lw_busy got=%b exp=0", bus.ls_ready); end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL lw_req_drop got=%b exp=0", bus.mem_req); end
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hDEADBEEF;
    tick();
    bus.mem_resp_valid = 1'b0;
    checks++; if (bus.done_to_queue !== 1'b1 || bus.cdb_valid !== 1'b1) begin failures++; $display("FAIL lw_done got done=%b cdb=%b exp 1 1", bus.done_to_queue, bus.cdb_valid); end
    checks++; if (bus.cdb_data !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", bus.cdb_data); end
    checks++; if (bus.cdb_tag !== 5'd7) begin failures++; $display("FAIL lw_tag got=%0d exp=7", bus.cdb_tag); end
    tick();
    checks++; if (bus.done_to_queue !== 1'b0 || bus.cdb_valid !== 1'b0) begin failures++; $display("FAIL lw_pulse_len got done=%b cdb=%b exp 0 0", bus.done_to_queue, bus.cdb_valid); end
    checks++; if (bus.ls_ready !== 1'b1) begin failures++; $display("FAIL lw_ready_after got=%b exp=1", bus.ls_ready); end
  endtask

  task automatic test_load_byte();
    logic [31:0] exp_data [2];
    exp_data[0] = 32'hFFFFFF80;
    exp_data[1] = 32'h00000080;
    for (int u = 0; u < 2; u++) begin
      accept_op(1'b1, 32'h200, 32'h3, 32'h0, 2'd0, u[0], 5'd3);
      checks++; if (bus.mem_be !== 4'b1000 || bus.mem_addr !== 32'h200)
        begin failures++; $display("FAIL lb_be_addr uns=%0d got be=%b addr=%h exp be=1000 addr=00000200", u, bus.mem_be, bus.mem_addr); end
      bus.mem_gnt = 1'b1;
      tick();
      bus.mem_gnt        = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'h80AABBCC;
      tick();
      bus.mem_resp_valid = 1'b0;
      checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_data !== exp_data[u])
        begin failures++; $display("FAIL lb_data uns=%0d got vld=%b data=%h exp vld=1 data=%h", u, bus.cdb_valid, bus.cdb_data, exp_data[u]); end
      tick();
    end
  endtask

  task automatic test_store_half();
    accept_op(1'b0, 32'h300, 32'h2, 32'h1234ABCD, 2'd1, 1'b0, 5'd9);
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_be !== 4'b1100)
      begin failures++; $display("FAIL sh_we_be got we=%b be=%b exp we=1 be=1100", bus.mem_we, bus.mem_be); end
    checks++; if (bus.mem_wdata !== 32'hABCD0000 || bus.mem_addr !== 32'h300)
      begin failures++; $display("FAIL sh_wdata got wdata=%h addr=%h exp abcd0000 00000300", bus.mem_wdata, bus.mem_addr); end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt        = 1'b0;
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    checks++; if (bus.done_to_queue !== 1'b1 || bus.cdb_valid !== 1'b0)
      begin failures++; $display("FAIL sh_done got done=%b cdb=%b exp done=1 cdb=0", bus.done_to_queue, bus.cdb_valid); end
    tick();
  endtask

  task automatic test_stall();
    int dones;
    accept_op(1'b1, 32'h400, 32'h10, 32'h0, 2'd2, 1'b0, 5'd1);
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h410 || bus.ls_ready !== 1'b0)
        begin failures++; $display("FAIL stall_hold cyc=%0d got req=%b addr=%h rdy=%b exp 1 00000410 0", c, bus.mem_req, bus.mem_addr, bus.ls_ready); end
      tick();
    end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt        = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0BADF00D;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      bus.mem_resp_valid = 1'b0;
      if (bus.done_to_queue === 1'b1) dones++;
    end
    checks++; if (dones != 1) begin failures++; $display("FAIL stall_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_flush();
    // Flush in WAIT: transaction completes, report muted.
    accept_op(1'b1, 32'h500, 32'h0, 32'h0, 2'd2, 1'b0, 5'd4);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.flush   = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h11111111;
    tick();
    bus.mem_resp_valid = 1'b0;
    checks++; if (bus.done_to_queue !== 1'b0 || bus.cdb_valid !== 1'b0 || bus.ls_ready !== 1'b0)
      begin failures++; $display("FAIL flw_muted got done=%b cdb=%b rdy=%b exp 0 0 0", bus.done_to_queue, bus.cdb_valid, bus.ls_ready); end
    tick();
    checks++; if (bus.ls_ready !== 1'b1) begin failures++; $display("FAIL flw_ready got=%b exp=1", bus.ls_ready); end
    // Next op runs normally.
    accept_op(1'b1, 32'h600, 32'h8, 32'h0, 2'd2, 1'b0, 5'd12);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt        = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hCAFEF00D;
    tick();
    bus.mem_resp_valid = 1'b0;
    checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_data !== 32'hCAFEF00D || bus.cdb_tag !== 5'd12)
      begin failures++; $display("FAIL flw_next got vld=%b data=%h tag=%0d exp 1 cafef00d 12", bus.cdb_valid, bus.cdb_data, bus.cdb_tag); end
    tick();
    // Flush in REQ without grant: abort.
    accept_op(1'b0, 32'h700, 32'h0, 32'h5, 2'd2, 1'b0, 5'd2);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.mem_req !== 1'b0 || bus.ls_ready !== 1'b1)
      begin failures++; $display("FAIL flreq_abort got req=%b rdy=%b exp 0 1", bus.mem_req, bus.ls_ready); end
    tick();
    checks++; if (bus.done_to_queue !== 1'b0) begin failures++; $display("FAIL flreq_nodone got=%b exp=0", bus.done_to_queue); end
    // Flush together with in_valid: op not accepted.
    bus.flush = 1'b1;
    accept_op(1'b1, 32'h800, 32'h0, 32'h0, 2'd2, 1'b0, 5'd5);
    bus.flush = 1'b0;
    checks++; if (bus.mem_req !== 1'b0 || bus.ls_ready !== 1'b1)
      begin failures++; $display("FAIL flidle_reject got req=%b rdy=%b exp 0 1", bus.mem_req, bus.ls_ready); end
  endtask

  task automatic test_async_reset();
    accept_op(1'b1, 32'h900, 32'h0, 32'h0, 2'd2, 1'b0, 5'd6);
    checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL ar_req_before got=%b exp=1", bus.mem_req); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.ls_ready !== 1'b1)
      begin failures++; $display("FAIL ar_immediate got req=%b rdy=%b exp 0 1", bus.mem_req, bus.ls_ready); end
    #2;
    reset = 1'b1;
    tick();
    checks++; if (bus.ls_ready !== 1'b1 || bus.mem_req !== 1'b0)
      begin failures++; $display("FAIL ar_after got rdy=%b req=%b exp 1 0", bus.ls_ready, bus.mem_req); end
  endtask

  task automatic test_timeout();
    int  cyc;
    bit  seen;
    accept_op(1'b1, 32'hA00, 32'h0, 32'h0, 2'd2, 1'b0, 5'd8);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 400) begin
      tick();
      cyc++;
      if (bus.done_to_queue === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || cyc < 200 || cyc > 300)
      begin failures++; $display("FAIL tmo_done got seen=%0d after=%0d cycles exp done within 200..300", seen, cyc); end
    checks++; if (bus.err !== 1'b1 || bus.cdb_valid !== 1'b0)
      begin failures++; $display("FAIL tmo_err got err=%b cdb=%b exp 1 0", bus.err, bus.cdb_valid); end
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h12345678;
    tick();
    bus.mem_resp_valid = 1'b0;
    checks++; if (bus.ls_ready !== 1'b1 || bus.err !== 1'b0) begin failures++; $display("FAIL tmo_idle got rdy=%b err=%b exp 1 0", bus.ls_ready, bus.err); end
    tick();
    checks++; if (bus.done_to_queue !== 1'b0 || bus.cdb_valid !== 1'b0 || bus.ls_ready !== 1'b1)
      begin failures++; $display("FAIL tmo_late_resp got done=%b cdb=%b rdy=%b exp 0 0 1", bus.done_to_queue, bus.cdb_valid, bus.ls_ready); end
  endtask

`ifdef LS_MISALIGN_TRAP_EN
  task automatic test_misalign();
    accept_op(1'b1, 32'h100, 32'h1, 32'h0, 2'd2, 1'b0, 5'd10);
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL trap_noreq got=%b exp=0", bus.mem_req); end
    checks++; if (bus.done_to_queue !== 1'b1 || bus.err !== 1'b1 || bus.cdb_valid !== 1'b0)
      begin failures++; $display("FAIL trap_done got done=%b err=%b cdb=%b exp 1 1 0", bus.done_to_queue, bus.err, bus.cdb_valid); end
    tick();
    checks++; if (bus.ls_ready !== 1'b1 || bus.mem_req !== 1'b0)
      begin failures++; $display("FAIL trap_after got rdy=%b req=%b exp 1 0", bus.ls_ready, bus.mem_req); end
  endtask
`else
  task automatic test_misalign();
    accept_op(1'b1, 32'h300, 32'h1, 32'h0, 2'd1, 1'b0, 5'd10);
    checks++; if (bus.mem_addr !== 32'h300 || bus.mem_be !== 4'b0011)
      begin failures++; $display("FAIL mis_lane got addr=%h be=%b exp 00000300 0011", bus.mem_addr, bus.mem_be); end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt        = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h1234F678;
    tick();
    bus.mem_resp_valid = 1'b0;
    checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_data !== 32'hFFFFF678 || bus.err !== 1'b0)
      begin failures++; $display("FAIL mis_data got vld=%b data=%h err=%b exp 1 fffff678 0", bus.cdb_valid, bus.cdb_data, bus.err); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_stall();
    test_flush();
    test_async_reset();
    test_misalign();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
